// File: rtl/lsu_bus_master_if.sv
// Data-memory bus between the LSU (master) and the memory/responder (slave).
// One outstanding word-aligned request at a time; responses carry the full read word.
interface lsu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [29:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store unit: turns one load or store into a single bus request,
// stalls the pipeline until it completes, extends load data, flags misalignment and timeouts.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [31:0]      ALUResultM,
    input  logic [31:0]      WriteDataM,
    input  logic [2:0]       funct3M,
    output logic             StallLSU,
    output logic             LoadValid,
    output logic [31:0]      LoadData,
    output logic             MisalignM,
    output logic             BusError,
    lsu_bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [29:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [15:0] r_cnt;
    logic [31:0] r_load_data;
    logic        r_bus_err;

    logic        w_pending;
    logic        w_misalign;
    logic        w_issue;
    logic        w_timeout;
    logic [1:0]  w_lane;
    logic [3:0]  w_strobe;

    // funct3[1:0] gives the access size: 00 byte, 01 half, anything else word.
    function automatic logic [3:0] f_strobe(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   f_strobe = 4'b0001 << lane;
            2'b01:   f_strobe = lane[1] ? 4'b1100 : 4'b0011;
            default: f_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] wd,
                                            input logic [3:0] strb);
        logic [31:0] rep;
        case (f3[1:0])
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        for (int i = 0; i < 4; i++) begin
            f_wdata[8*i +: 8] = strb[i] ? rep[8*i +: 8] : 8'h00;
        end
    endfunction

    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] rdata);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        sh = rdata >> {lane, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  s = b;
            3'b001:  s = h;
            3'b100:  s = {24'h000000, sh[7:0]};
            3'b101:  s = {16'h0000, sh[15:0]};
            default: s = rdata;
        endcase
        f_extend = s;
    endfunction

    assign w_lane     = ALUResultM[1:0];
    assign w_pending  = MemReadM | MemWriteM;
    assign w_misalign = w_pending &&
                        (((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                         (funct3M[1] && (ALUResultM[1:0] != 2'b00)));
    assign w_issue    = (r_state == IDLE) && w_pending && !w_misalign;
    assign w_timeout  = (r_state == WAIT_RSP) && !bus.rsp_valid &&
                        (r_cnt == 16'(TIMEOUT - 1));
    assign w_strobe   = MemWriteM ? f_strobe(funct3M, w_lane) : 4'b0000;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_issue) w_next = REQ;
            REQ:      if (bus.req_ready) w_next = WAIT_RSP;
            WAIT_RSP: if (bus.rsp_valid || w_timeout) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_cnt       <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= w_timeout;
            r_cnt     <= (r_state == WAIT_RSP) ? r_cnt + 16'd1 : 16'd0;
            if (w_issue) begin
                r_we     <= MemWriteM;
                r_addr   <= ALUResultM[31:2];
                r_wstrb  <= w_strobe;
                r_wdata  <= MemWriteM ? f_wdata(funct3M, WriteDataM, w_strobe) : 32'h0;
                r_funct3 <= funct3M;
                r_lane   <= w_lane;
            end
            // A timed-out load still completes, with a zero result.
            if ((r_state == WAIT_RSP) && bus.rsp_valid && !r_we)
                r_load_data <= f_extend(r_funct3, r_lane, bus.rsp_rdata);
            else if (w_timeout && !r_we)
                r_load_data <= 32'h0;
        end
    end

    assign StallLSU      = w_issue || (r_state == REQ) || (r_state == WAIT_RSP);
    assign MisalignM     = (r_state == IDLE) && w_misalign;
    assign LoadValid     = (r_state == DONE) && !r_we;
    assign LoadData      = r_load_data;
    assign BusError      = r_bus_err;
    assign bus.req_valid = (r_state == REQ);
    assign bus.req_we    = r_we;
    assign bus.req_addr  = r_addr;
    assign bus.req_wstrb = r_wstrb;
    assign bus.req_wdata = r_wdata;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed scenarios plus randomized accesses against a
// byte-level reference model of strobes, lane placement, extension and latency.
module tb_lsu_bus_master;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  funct3M;
    logic        StallLSU, LoadValid, MisalignM, BusError;
    logic [31:0] LoadData;

    lsu_bus_master_if bus();

    lsu_bus_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
        .StallLSU(StallLSU), .LoadValid(LoadValid), .LoadData(LoadData),
        .MisalignM(MisalignM), .BusError(BusError),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // observations of one access
    int          ob_stall, ob_lv, ob_be, ob_mis, ob_rv, ob_wait, ob_post;
    logic        ob_unstable, ob_be_done, ob_hang, ob_we;
    logic [29:0] ob_addr;
    logic [3:0]  ob_strb;
    logic [31:0] ob_wdata, ob_ldata;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: m_size = 1;
            3'd1, 3'd5: m_size = 2;
            default:    m_size = 4;
        endcase
    endfunction

    function automatic logic m_misaligned(input logic [31:0] a, input logic [2:0] f3);
        m_misaligned = (a % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic we, input logic [31:0] a, input logic [2:0] f3);
        int n;
        n = m_size(f3);
        m_strb = we ? 4'(((1 << n) - 1) << (a % 4)) : 4'h0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic we, input logic [31:0] a,
                                            input logic [2:0] f3, input logic [31:0] wd);
        longint unsigned mask, v;
        mask = (64'd1 << (8 * m_size(f3))) - 1;
        v = ({32'h0, wd} & mask) << (8 * (a % 4));
        m_wdata = we ? v[31:0] : 32'h0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3,
                                           input logic [31:0] rd);
        longint unsigned mask, v;
        int n;
        n = m_size(f3);
        mask = (64'd1 << (8 * n)) - 1;
        v = ({32'h0, rd} >> (8 * (a % 4))) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | (~mask & 64'hFFFF_FFFF);
        m_load = v[31:0];
    endfunction

    // ---------------- driver + responder for one access ----------------
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input int rdy_dly, input int rsp_dly,
                              input logic [31:0] rdata);
        int   widx;
        logic in_wait, done;
        ob_stall = 0; ob_lv = 0; ob_be = 0; ob_mis = 0; ob_rv = 0; ob_wait = 0; ob_post = 0;
        ob_unstable = 0; ob_be_done = 0; ob_hang = 0; ob_ldata = 'x;
        ob_we = 'x; ob_addr = 'x; ob_strb = 'x; ob_wdata = 'x;
        widx = 0; in_wait = 0; done = 0;
        @(posedge clk); #1;
        MemWriteM = we; MemReadM = !we; ALUResultM = addr; WriteDataM = wd; funct3M = f3;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = rdata;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (StallLSU) ob_stall++;
            if (LoadValid) begin ob_lv++; ob_ldata = LoadData; end
            if (BusError) ob_be++;
            if (MisalignM) ob_mis++;
            if (in_wait && StallLSU) ob_wait++;
            if (in_wait) begin
                bus.rsp_valid = (rsp_dly >= 0) && (widx == rsp_dly);
                widx++;
            end
            if (bus.req_valid) begin
                if (ob_rv == 0) begin
                    ob_we = bus.req_we; ob_addr = bus.req_addr;
                    ob_strb = bus.req_wstrb; ob_wdata = bus.req_wdata;
                end else if ({bus.req_we, bus.req_addr, bus.req_wstrb, bus.req_wdata} !==
                             {ob_we, ob_addr, ob_strb, ob_wdata}) begin
                    ob_unstable = 1;
                end
                ob_rv++;
                bus.req_ready = (ob_rv > rdy_dly);
                if (bus.req_ready) in_wait = 1;
            end else begin
                bus.req_ready = 0;
            end
            if (!StallLSU) begin done = 1; ob_be_done = BusError; end
        end
        if (!done) ob_hang = 1;
        @(posedge clk); #1;
        MemReadM = 0; MemWriteM = 0; bus.req_ready = 0; bus.rsp_valid = 0;
        @(negedge clk);
        ob_post = int'(LoadValid) + int'(BusError) + int'(MisalignM) + int'(bus.req_valid) + int'(StallLSU);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({StallLSU, LoadValid, MisalignM, BusError} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {StallLSU, LoadValid, MisalignM, BusError}); end
        n_cmp++; if (LoadData !== 32'h0) begin n_err++; $display("FAIL reset_loaddata got %h want 0", LoadData); end
        n_cmp++; if ({bus.req_valid, bus.req_we, bus.req_addr, bus.req_wstrb, bus.req_wdata} !== 67'h0) begin n_err++; $display("FAIL reset_req got v%b we%b a%h s%h d%h want all 0", bus.req_valid, bus.req_we, bus.req_addr, bus.req_wstrb, bus.req_wdata); end
        @(posedge clk); #1 rst = 0;
    endtask

    task automatic test_store_word();
        run_access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 32'h0);
        n_cmp++; if (ob_addr !== 30'h40) begin n_err++; $display("FAIL sw_addr got %h want 40", ob_addr); end
        n_cmp++; if (ob_strb !== 4'b1111) begin n_err++; $display("FAIL sw_strb got %b want 1111", ob_strb); end
        n_cmp++; if (ob_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata got %h want deadbeef", ob_wdata); end
        n_cmp++; if (ob_we !== 1'b1) begin n_err++; $display("FAIL sw_we got %b want 1", ob_we); end
        n_cmp++; if (ob_stall !== 3) begin n_err++; $display("FAIL sw_stall got %0d want 3", ob_stall); end
        n_cmp++; if (ob_lv !== 0 || ob_post !== 0 || ob_hang) begin n_err++; $display("FAIL sw_pulses got lv=%0d post=%0d hang=%b want 0 0 0", ob_lv, ob_post, ob_hang); end
    endtask

    task automatic test_store_lanes();
        run_access(1'b1, 32'h103, 32'h123456A5, 3'b000, 0, 0, 32'h0);
        n_cmp++; if (ob_strb !== 4'b1000) begin n_err++; $display("FAIL sb_strb got %b want 1000", ob_strb); end
        n_cmp++; if (ob_wdata !== 32'hA5000000) begin n_err++; $display("FAIL sb_wdata got %h want a5000000", ob_wdata); end
        run_access(1'b1, 32'h102, 32'hABCD1234, 3'b001, 1, 2, 32'h0);
        n_cmp++; if (ob_strb !== 4'b1100) begin n_err++; $display("FAIL sh_strb got %b want 1100", ob_strb); end
        n_cmp++; if (ob_wdata !== 32'h12340000) begin n_err++; $display("FAIL sh_wdata got %h want 12340000", ob_wdata); end
        n_cmp++; if (ob_stall !== 1 + 2 + 3) begin n_err++; $display("FAIL sh_stall got %0d want 6", ob_stall); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280};
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, 32'h102, 32'h0, f3s[i], 0, 0, 32'h12803456);
            n_cmp++; if (ob_ldata !== exp[i]) begin n_err++; $display("FAIL load_ext%0d got %h want %h", i, ob_ldata, exp[i]); end
            n_cmp++; if (ob_lv !== 1 || ob_post !== 0) begin n_err++; $display("FAIL load_lv%0d got lv=%0d post=%0d want 1 0", i, ob_lv, ob_post); end
            n_cmp++; if ({ob_we, ob_addr, ob_strb, ob_wdata} !== {1'b0, 30'h40, 4'h0, 32'h0}) begin n_err++; $display("FAIL load_req%0d got we%b a%h s%h d%h want 0 40 0 0", i, ob_we, ob_addr, ob_strb, ob_wdata); end
        end
    endtask

    task automatic test_misalign();
        run_access(1'b0, 32'h101, 32'h0, 3'b001, 0, 0, 32'h0);
        n_cmp++; if (ob_mis !== 1) begin n_err++; $display("FAIL mis_pulse got %0d want 1", ob_mis); end
        n_cmp++; if (ob_rv !== 0 || ob_stall !== 0) begin n_err++; $display("FAIL mis_noreq got rv=%0d stall=%0d want 0 0", ob_rv, ob_stall); end
        n_cmp++; if (ob_post !== 0) begin n_err++; $display("FAIL mis_post got %0d want 0", ob_post); end
    endtask

    task automatic test_backpressure_timeout();
        run_access(1'b0, 32'h200, 32'h0, 3'b010, 5, -1, 32'h55AA55AA);
        n_cmp++; if (ob_rv !== 6 || ob_unstable) begin n_err++; $display("FAIL bp_req got rv=%0d unstable=%b want 6 0", ob_rv, ob_unstable); end
        n_cmp++; if (ob_wait !== TMO) begin n_err++; $display("FAIL tmo_wait got %0d want %0d", ob_wait, TMO); end
        n_cmp++; if (ob_be !== 1 || !ob_be_done) begin n_err++; $display("FAIL tmo_buserr got cnt=%0d at_done=%b want 1 1", ob_be, ob_be_done); end
        n_cmp++; if (ob_lv !== 1 || ob_ldata !== 32'h0) begin n_err++; $display("FAIL tmo_load got lv=%0d data=%h want 1 0", ob_lv, ob_ldata); end
        n_cmp++; if (ob_stall !== 1 + 6 + TMO || ob_post !== 0) begin n_err++; $display("FAIL tmo_stall got %0d post=%0d want %0d 0", ob_stall, ob_post, 1 + 6 + TMO); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        run_access(1'b0, 32'h20, 32'h0, 3'b010, 0, 0, 32'hCAFEF00D);
        n_cmp++; if (ob_ldata !== 32'hCAFEF00D) begin n_err++; $display("FAIL rm_pre got %h want cafef00d", ob_ldata); end
        @(posedge clk); #1;
        MemReadM = 1; MemWriteM = 0; ALUResultM = 32'h44; funct3M = 3'b010;
        bus.req_ready = 1; bus.rsp_valid = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (StallLSU !== 1'b1 || bus.req_valid !== 1'b0) begin n_err++; $display("FAIL rm_inwait got stall=%b valid=%b want 1 0", StallLSU, bus.req_valid); end
        rst = 1; MemReadM = 0; bus.req_ready = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        n_cmp++; if ({StallLSU, LoadValid, MisalignM, BusError, LoadData} !== 36'h0) begin n_err++; $display("FAIL rm_outs got st%b lv%b m%b be%b ld%h want all 0", StallLSU, LoadValid, MisalignM, BusError, LoadData); end
        n_cmp++; if ({bus.req_valid, bus.req_we, bus.req_addr, bus.req_wstrb, bus.req_wdata} !== 67'h0) begin n_err++; $display("FAIL rm_req got v%b a%h s%h d%h want all 0", bus.req_valid, bus.req_addr, bus.req_wstrb, bus.req_wdata); end
        rd = $urandom;
        run_access(1'b0, 32'h10, 32'h0, 3'b010, 0, 0, rd);
        n_cmp++; if (ob_ldata !== rd || ob_addr !== 30'h4 || ob_stall !== 3) begin n_err++; $display("FAIL rm_after got d=%h a=%h st=%0d want %h 4 3", ob_ldata, ob_addr, ob_stall, rd); end
    endtask

    task automatic test_random();
        logic        we, mis;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        int          rdy, rsp, exp_stall;
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom_range(0, 1));
            f3  = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a   = $urandom; wd = $urandom; rd = $urandom;
            rdy = $urandom_range(0, 3);
            rsp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            mis = m_misaligned(a, f3);
            run_access(we, a, wd, f3, rdy, rsp, rd);
            n_cmp++; if (ob_hang || ob_unstable || ob_post !== 0) begin n_err++; $display("FAIL rnd%0d_proto got hang=%b unstable=%b post=%0d want 0 0 0", i, ob_hang, ob_unstable, ob_post); end
            if (mis) begin
                n_cmp++; if (ob_mis !== 1 || ob_rv !== 0 || ob_stall !== 0) begin n_err++; $display("FAIL rnd%0d_mis got m=%0d rv=%0d st=%0d want 1 0 0", i, ob_mis, ob_rv, ob_stall); end
            end else begin
                exp_stall = 2 + rdy + ((rsp < 0) ? TMO : rsp + 1);
                n_cmp++; if (ob_mis !== 0 || ob_stall !== exp_stall || ob_be !== int'(rsp < 0)) begin n_err++; $display("FAIL rnd%0d_ctl got m=%0d st=%0d be=%0d want 0 %0d %0d", i, ob_mis, ob_stall, ob_be, exp_stall, int'(rsp < 0)); end
                n_cmp++; if ({ob_we, ob_addr, ob_strb, ob_wdata} !== {we, a[31:2], m_strb(we, a, f3), m_wdata(we, a, f3, wd)}) begin n_err++; $display("FAIL rnd%0d_req got we%b a%h s%b d%h want %b %h %b %h", i, ob_we, ob_addr, ob_strb, ob_wdata, we, a[31:2], m_strb(we, a, f3), m_wdata(we, a, f3, wd)); end
                n_cmp++; if (ob_lv !== int'(!we)) begin n_err++; $display("FAIL rnd%0d_lv got %0d want %0d", i, ob_lv, int'(!we)); end
                if (!we) begin
                    n_cmp++; if (ob_ldata !== ((rsp < 0) ? 32'h0 : m_load(a, f3, rd))) begin n_err++; $display("FAIL rnd%0d_ld got %h want %h", i, ob_ldata, (rsp < 0) ? 32'h0 : m_load(a, f3, rd)); end
                end
            end
        end
    endtask

    initial begin
        rst = 1; MemReadM = 0; MemWriteM = 0; ALUResultM = 0; WriteDataM = 0; funct3M = 0;
        bus.req_ready = 0; bus.rsp_valid = 0; bus.rsp_rdata = 0;
        test_reset();
        test_store_word();
        test_store_lanes();
        test_load_ext();
        test_misalign();
        test_backpressure_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Initiator side of the MEM-stage data-memory interface. Takes one load or store per instruction from the MEM stage and converts it to a single word-aligned bus request with byte strobes and lane-aligned write data. It waits for the memory's response and sign/zero-extends load data from the returned word. It stalls the pipeline while the access is outstanding, flags misaligned accesses, and times out a silent responder.

## Interface
- TIMEOUT, 255: max cycles in WAIT_RSP before a bus error; 1..65535.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- MemReadM  in  1  MEM-stage load.
- MemWriteM  in  1  MEM-stage store; has priority if both are set.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data; the low byte or half is used for SB/SH.
- funct3M  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- StallLSU  out  1  freeze IF..MEM.
- LoadValid  out  1  one-cycle pulse when LoadData is valid for the completed load.
- LoadData  out  32  extended load result, held until the next load completes.
- MisalignM  out  1  one-cycle pulse; the access is not issued.
- BusError  out  1  one-cycle pulse on timeout.
- req_valid  out  1  bus request.
- req_ready  in  1  request accepted.
- req_we  out  1  1 = write.
- req_addr  out  30  word address, ALUResultM[31:2].
- req_wstrb  out  4  byte enables, bit i = byte lane i.
- req_wdata  out  32  lane-aligned write data; lanes not enabled by req_wstrb are 0.
- rsp_valid  in  1  response or write acknowledge.
- rsp_rdata  in  32  full read word.

## Operation
- **States:** IDLE, REQ, WAIT_RSP, DONE. Reset state is IDLE.
- **IDLE.** An access is pending when MemReadM or MemWriteM is 1.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Pulse MisalignM and stay in IDLE. No stall, no request.
  - Aligned: latch req_we, req_addr, strobes, aligned wdata, funct3 and addr[1:0], then go to REQ.
- **Strobes and write data:**
  - W: strobe 1111, wdata = WriteDataM.
  - H: strobe 0011 or 1100 by addr[1], half placed in bits [15:0] or [31:16].
  - B: strobe one-hot at lane addr[1:0], byte placed at bits [8k+7:8k].
  - Loads drive req_wstrb = 0000 and req_wdata = 0.
- **REQ.** req_valid=1 with all req_* outputs held stable until req_ready. On the handshake (valid & ready), go to WAIT_RSP.
- **WAIT_RSP.** Wait for rsp_valid; reads and writes both complete this way.
  - On rsp_valid: for a load, register the extended value into LoadData, then go to DONE.
  - Extension: select the byte at lane addr[1:0], or the half at addr[1]. Sign-extend for B/H, zero-extend for BU/HU, pass the word through for W.
  - Timeout: a counter starts at 0 on entry and increments each cycle. If it reaches TIMEOUT without rsp_valid: pulse BusError, set LoadData = 0 for a load, go to DONE.
  - rsp_valid is ignored in every state other than WAIT_RSP.
- **DONE.** StallLSU=0, so the pipeline advances the completed instruction at this edge. LoadValid=1 for loads, including a load ending in BusError. MemRead/MemWrite inputs are ignored here, so the same instruction is never re-issued. Go to IDLE.
- **Reset mid-operation.** Return to IDLE; req_valid drops next cycle and any outstanding request is abandoned. The responder must tolerate this.

## Timing
- **Reset values:** every output is 0, including LoadData and req_*.
- **StallLSU** = (IDLE & aligned pending access) | REQ | WAIT_RSP. It is combinational in IDLE, so it asserts in the same cycle the access appears.
- **Minimum latency:** req_ready=1 in the first REQ cycle and rsp_valid in the first WAIT_RSP cycle gives:
  - cycle 0: IDLE detect;
  - cycle 1: REQ;
  - cycle 2: WAIT_RSP;
  - cycle 3: DONE.
  - StallLSU is high for cycles 0–2. LoadData/LoadValid are valid in cycle 3.
- **Timeout:** BusError pulses in the cycle the state leaves WAIT_RSP, TIMEOUT cycles after WAIT_RSP entry.
- **Back-to-back:** a new access is detected at the earliest in the cycle after DONE.
- **Pulse outputs:** MisalignM, BusError and LoadValid are exactly one cycle wide.

## Test plan
- **SW, immediate bus:** SW 0xDEADBEEF to 0x100, req_ready=1, rsp_valid one cycle later → req_addr=0x40, req_wstrb=1111, req_wdata=0xDEADBEEF, req_we=1, StallLSU high exactly 3 cycles.
- **SB lane placement:** SB 0x000000A5 to 0x103 → req_wstrb=1000, req_wdata=0xA5000000. SH 0x1234 to 0x102 → req_wstrb=1100, req_wdata=0x12340000.
- **Load extension:** LB at 0x102 with rsp_rdata=0x12803456 → LoadData=0xFFFFFF80. LBU gives 0x00000080. LH at 0x102 gives 0x00001280. LoadValid is a single pulse in each case.
- **Misaligned:** LH at 0x101 → MisalignM single pulse, req_valid stays 0, StallLSU stays 0.
- **Backpressure and timeout:** hold req_ready=0 for 5 cycles → req_* stable throughout. Then raise req_ready and never send rsp_valid (TIMEOUT=8) → BusError after 8 WAIT_RSP cycles, LoadData=0, LoadValid pulses.
- **Reset mid-operation:** assert rst during WAIT_RSP → next cycle IDLE, all outputs 0. A following LW at 0x10 then completes normally.
